// File: rtl/fetch_byte_queue_if.sv
`default_nettype none
// ============================================================================
// fetch_byte_queue_if : ICache request/response, redirect and decoder window bus
// Revision : 1.0
// ============================================================================
interface fetch_byte_queue_if #(
    parameter int LINE_BYTES = 64,
    parameter int DEC_BYTES  = 15
);
    logic                         set_rip;
    logic [63:0]                  new_rip;
    logic                         icache_enable;
    logic [63:0]                  icache_addr;
    logic [LINE_BYTES*8-1:0]      icache_rdata;
    logic                         icache_done;
    logic                         decode_valid;
    logic                         decode_ready;
    logic [0:DEC_BYTES*8-1]       decode_bytes;
    logic [63:0]                  decode_rip;
    logic [7:0]                   bytes_decoded;

    modport master (
        input  set_rip, new_rip, icache_rdata, icache_done, decode_ready, bytes_decoded,
        output icache_enable, icache_addr, decode_valid, decode_bytes, decode_rip
    );

    modport slave (
        output set_rip, new_rip, icache_rdata, icache_done, decode_ready, bytes_decoded,
        input  icache_enable, icache_addr, decode_valid, decode_bytes, decode_rip
    );
endinterface
`default_nettype wire

// File: rtl/fetch_byte_queue.sv
`default_nettype none
// ============================================================================
// fetch_byte_queue : fetches ICache lines into a byte queue feeding the decoder
// Revision : 1.0
// ============================================================================
module fetch_byte_queue #(
    parameter int LINE_BYTES  = 64,
    parameter int QUEUE_BYTES = 32,
    parameter int DEC_BYTES   = 15
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    fetch_byte_queue_if.master bus
);
    localparam int c_OFF_W   = $clog2(LINE_BYTES);
    localparam int c_CNT_W   = $clog2(LINE_BYTES + QUEUE_BYTES + 1);
    localparam int c_QBITS   = QUEUE_BYTES * 8;
    localparam int c_MIN_REQ = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_load_addr;
    logic [63:0]            w_req_src;

    logic [c_QBITS-1:0]     r_queue;
    logic [c_QBITS-1:0]     w_next_queue;
    logic [c_QBITS-1:0]     w_q_shift;
    logic [c_QBITS-1:0]     w_l_place;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_CNT_W-1:0]     w_free;
    logic [c_CNT_W-1:0]     w_line_left;
    logic [c_CNT_W-1:0]     w_min_req;
    logic [c_CNT_W-1:0]     w_push_n;
    logic [c_CNT_W-1:0]     w_pop_n;
    logic [c_CNT_W-1:0]     w_remain;
    logic [c_CNT_W-1:0]     w_next_count;
    logic [c_OFF_W-1:0]     w_off;
    logic [63:0]            r_fetch_addr;
    logic [63:0]            r_rip;
    logic [63:0]            r_addr;
    logic                   r_valid;
    logic                   r_started;
    logic                   w_push;
    logic                   w_pop_ok;
    logic [0:DEC_BYTES*8-1] w_window;

    // Queue datapath: free is taken before the pop, pushed bytes append after the survivors
    always_comb begin
        w_off        = r_fetch_addr[c_OFF_W-1:0];
        w_free       = c_CNT_W'(QUEUE_BYTES) - r_count;
        w_line_left  = c_CNT_W'(LINE_BYTES) - c_CNT_W'(w_off);
        w_min_req    = (w_line_left < c_CNT_W'(c_MIN_REQ)) ? w_line_left : c_CNT_W'(c_MIN_REQ);
        w_push       = (r_state == S_REQ) && bus.icache_done && !bus.set_rip;
        w_push_n     = '0;
        if (w_push) begin
            w_push_n = (w_line_left < w_free) ? w_line_left : w_free;
        end
        w_pop_ok     = r_valid && bus.decode_ready && (bus.bytes_decoded != 8'd0)
                       && (bus.bytes_decoded <= 8'(DEC_BYTES));
        w_pop_n      = w_pop_ok ? c_CNT_W'(bus.bytes_decoded) : '0;
        w_remain     = r_count - w_pop_n;
        w_next_count = w_remain + w_push_n;
        w_q_shift    = r_queue >> {w_pop_n, 3'b000};
        w_l_place    = c_QBITS'(bus.icache_rdata >> {w_off, 3'b000}) << {w_remain, 3'b000};
        w_next_queue = '0;
        for (int i = 0; i < QUEUE_BYTES; i++) begin
            if (c_CNT_W'(i) < w_remain) begin
                w_next_queue[8*i +: 8] = w_q_shift[8*i +: 8];
            end else if (c_CNT_W'(i) < w_next_count) begin
                w_next_queue[8*i +: 8] = w_l_place[8*i +: 8];
            end
        end
        w_window = '0;
        for (int i = 0; i < DEC_BYTES; i++) begin
            w_window[8*i +: 8] = r_queue[8*i +: 8];
        end
    end

    // A redirect from IDLE issues its request straight away, from the new target
    always_comb begin
        w_state_next = r_state;
        w_load_addr  = 1'b0;
        w_req_src    = bus.set_rip ? bus.new_rip : r_fetch_addr;
        case (r_state)
            S_IDLE: begin
                if (bus.set_rip || (r_started && (w_free >= w_min_req))) begin
                    w_state_next = S_REQ;
                    w_load_addr  = 1'b1;
                end
            end
            S_REQ: begin
                if (bus.icache_done) begin
                    w_state_next = S_IDLE;
                end else if (bus.set_rip) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.icache_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_queue      <= '0;
            r_count      <= '0;
            r_fetch_addr <= '0;
            r_rip        <= '0;
            r_addr       <= '0;
            r_valid      <= 1'b0;
            r_started    <= 1'b0;
        end else begin
            if (w_load_addr) begin
                r_addr <= {w_req_src[63:c_OFF_W], {c_OFF_W{1'b0}}};
            end
            if (bus.set_rip) begin
                r_count      <= '0;
                r_rip        <= bus.new_rip;
                r_fetch_addr <= bus.new_rip;
                r_valid      <= 1'b0;
                r_started    <= 1'b1;
            end else begin
                r_queue      <= w_next_queue;
                r_count      <= w_next_count;
                r_valid      <= (w_next_count >= c_CNT_W'(DEC_BYTES));
                r_rip        <= r_rip + 64'(w_pop_n);
                r_fetch_addr <= r_fetch_addr + 64'(w_push_n);
            end
        end
    end

    assign bus.icache_enable = (r_state != S_IDLE);
    assign bus.icache_addr   = r_addr;
    assign bus.decode_valid  = r_valid;
    assign bus.decode_rip    = r_rip;
    assign bus.decode_bytes  = w_window;

endmodule
`default_nettype wire

// File: tb/tb_fetch_byte_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_byte_queue : scoreboard bench for fetch_byte_queue with an ICache model
// Revision : 1.0
// ============================================================================
module tb_fetch_byte_queue;
    localparam int LB = 64;
    localparam int QB = 32;
    localparam int DB = 15;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fetch_byte_queue_if #(.LINE_BYTES(LB), .DEC_BYTES(DB)) ifc ();

    fetch_byte_queue #(.LINE_BYTES(LB), .QUEUE_BYTES(QB), .DEC_BYTES(DB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] req_q[$];
    logic [63:0] win_q[$];
    int          lat = 3;

    // ICache content: every byte holds the low byte of its own address
    function automatic logic [LB*8-1:0] line_data(input logic [63:0] base);
        logic [LB*8-1:0] d;
        logic [63:0]     a;
        for (int k = 0; k < LB; k++) begin
            a = base + 64'(k);
            d[8*k +: 8] = a[7:0];
        end
        return d;
    endfunction

    function automatic logic [0:DB*8-1] exp_win(input logic [63:0] rip);
        logic [0:DB*8-1] w;
        logic [63:0]     a;
        for (int i = 0; i < DB; i++) begin
            a = rip + 64'(i);
            w[8*i +: 8] = a[7:0];
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ICache responder: done arrives lat cycles into the request, for one cycle
    int          wait_n = 0;
    logic [63:0] arm_addr;
    task automatic fire();
        ifc.icache_rdata = line_data(ifc.icache_addr);
        ifc.icache_done  = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            wait_n          = 0;
            ifc.icache_done = 1'b0;
        end else if (ifc.icache_done) begin
            ifc.icache_done = 1'b0;
        end else if (wait_n > 0) begin
            chk("icache_addr_stable", 128'(ifc.icache_addr), 128'(arm_addr));
            wait_n--;
            if (wait_n == 0) fire();
        end else if (ifc.icache_enable) begin
            arm_addr = ifc.icache_addr;
            wait_n   = lat - 1;
            if (wait_n == 0) fire();
        end
    end

    // Request monitor
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        logic [63:0] e;
        if (ifc.icache_enable && !prev_en) begin
            if (req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_request: got %h expected none", ifc.icache_addr);
            end else begin
                e = req_q.pop_front();
                chk("icache_addr", 128'(ifc.icache_addr), 128'(e));
            end
        end
        prev_en = ifc.icache_enable;
    end

    // Window monitor: every accepted pop is matched against the expected rip
    always @(negedge clk) begin
        logic [63:0] e;
        if (ifc.decode_valid && ifc.decode_ready && ifc.bytes_decoded >= 8'd1
            && ifc.bytes_decoded <= 8'(DB)) begin
            if (win_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_accept: got rip %h expected none", ifc.decode_rip);
            end else begin
                e = win_q.pop_front();
                chk("accept_rip", 128'(ifc.decode_rip), 128'(e));
                chk("accept_bytes", 128'(ifc.decode_bytes), 128'(exp_win(e)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [63:0] a);
        ifc.set_rip = 1'b1;
        ifc.new_rip = a;
        step();
        ifc.set_rip = 1'b0;
    endtask

    task automatic pop(input int n);
        ifc.decode_ready  = 1'b1;
        ifc.bytes_decoded = 8'(n);
        step();
        ifc.decode_ready  = 1'b0;
        ifc.bytes_decoded = 8'd0;
    endtask

    task automatic wait_en(input logic lvl);
        int n = 0;
        while (ifc.icache_enable !== lvl && n < 50) begin
            step();
            n++;
        end
        if (ifc.icache_enable !== lvl) begin
            checks++;
            errors++;
            $display("FAIL wait_enable timeout: got %b expected %b", ifc.icache_enable, lvl);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (ifc.decode_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (ifc.decode_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_valid timeout: got %b expected 1", ifc.decode_valid);
        end
    endtask

    task automatic check_window(input string name, input logic [63:0] rip);
        chk({name, "_valid"}, 128'(ifc.decode_valid), 128'(1'b1));
        chk({name, "_rip"},   128'(ifc.decode_rip),   128'(rip));
        chk({name, "_bytes"}, 128'(ifc.decode_bytes), 128'(exp_win(rip)));
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_enable"}, 128'(ifc.icache_enable), 128'(1'b0));
        chk({name, "_addr"},   128'(ifc.icache_addr),   128'(64'h0));
        chk({name, "_valid"},  128'(ifc.decode_valid),  128'(1'b0));
        chk({name, "_rip"},    128'(ifc.decode_rip),    128'(64'h0));
        chk({name, "_bytes"},  128'(ifc.decode_bytes),  128'(0));
    endtask

    initial begin
        int n;
        reset_n           = 1'b0;
        ifc.set_rip       = 1'b0;
        ifc.new_rip       = 64'h0;
        ifc.decode_ready  = 1'b0;
        ifc.bytes_decoded = 8'd0;
        repeat (3) step();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (6) step();
        chk("idle_before_redirect", 128'(ifc.icache_enable), 128'(1'b0));

        // 1: first line from 0x1000 fills the queue
        req_q.push_back(64'h1000);
        redirect(64'h1000);
        chk("enable_after_redirect", 128'(ifc.icache_enable), 128'(1'b1));
        wait_valid();
        check_window("fill", 64'h1000);
        repeat (2) step();
        chk("full_no_request", 128'(ifc.icache_enable), 128'(1'b0));

        // 3: single pop, then a streaming pop that overlaps a refill
        win_q.push_back(64'h1000);
        pop(3);
        check_window("pop3", 64'h1003);
        lat = 1;
        req_q.push_back(64'h1000);
        for (int i = 0; i < 20; i++) win_q.push_back(64'h1003 + 64'(i));
        ifc.decode_ready  = 1'b1;
        ifc.bytes_decoded = 8'd1;
        n = 0;
        while (win_q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        ifc.decode_ready  = 1'b0;
        ifc.bytes_decoded = 8'd0;
        chk("stream_drained", 128'(win_q.size()), 128'(0));
        chk("stream_request_seen", 128'(req_q.size()), 128'(0));
        check_window("stream", 64'h1017);

        // 5: out-of-range pop counts are ignored
        ifc.decode_ready  = 1'b1;
        ifc.bytes_decoded = 8'd0;
        repeat (2) step();
        ifc.bytes_decoded = 8'd16;
        repeat (2) step();
        ifc.decode_ready  = 1'b0;
        ifc.bytes_decoded = 8'd0;
        check_window("bad_pop", 64'h1017);

        // 4: redirect while a request is outstanding
        lat = 3;
        win_q.push_back(64'h1017);
        req_q.push_back(64'h1000);
        pop(15);
        wait_en(1'b1);
        req_q.push_back(64'h2000);
        redirect(64'h2000);
        chk("drain_enable_held", 128'(ifc.icache_enable), 128'(1'b1));
        chk("drain_valid", 128'(ifc.decode_valid), 128'(1'b0));
        chk("drain_rip", 128'(ifc.decode_rip), 128'(64'h2000));
        wait_valid();
        check_window("after_drain", 64'h2000);

        // 2: redirect near the line end
        req_q.push_back(64'h1000);
        req_q.push_back(64'h1040);
        redirect(64'h103A);
        wait_en(1'b1);
        wait_en(1'b0);
        chk("partial_line_valid", 128'(ifc.decode_valid), 128'(1'b0));
        wait_valid();
        check_window("next_line", 64'h103A);

        // 64-bit address wrap for fetch and decode
        req_q.push_back(64'hFFFF_FFFF_FFFF_FFC0);
        req_q.push_back(64'h0);
        redirect(64'hFFFF_FFFF_FFFF_FFF8);
        wait_valid();
        check_window("wrap_fill", 64'hFFFF_FFFF_FFFF_FFF8);
        win_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
        pop(10);
        check_window("wrap_pop", 64'h2);

        // 6: reset in the middle of a request
        req_q.push_back(64'h3000);
        redirect(64'h3000);
        chk("pre_reset_enable", 128'(ifc.icache_enable), 128'(1'b1));
        reset_n = 1'b0;
        step();
        check_reset_outputs("mid_reset");
        reset_n = 1'b1;
        repeat (6) step();
        chk("idle_after_reset", 128'(ifc.icache_enable), 128'(1'b0));

        chk("req_queue_empty", 128'(req_q.size()), 128'(0));
        chk("win_queue_empty", 128'(win_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
